// File: rtl/i2c_target.sv
// I2C target responder: exposes a byte-addressed register space through a
// write-strobe / read-address port, driving SDA only through an open-drain enable.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         PTR_W    = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_WACK, ST_WDATA, ST_RDATA, ST_RDATA_ACK
  } state_t;

  localparam logic [PTR_W-1:0] PTR_INC = PTR_W'(1);

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         sr_q, sr_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               sda_oe_q, sda_oe_d;
  logic               busy_q, busy_d;
  logic               wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               rw_q, rw_d;
  logic               ack_q, ack_d;

  logic       scl_rise_s, scl_fall_s, scl_high_s, start_s, stop_s;
  logic [7:0] byte_s;

  // Pin synchronizers plus previous-value registers; idle bus is high.
  always_ff @(posedge CLK) begin
    if (reset) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_prev_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_in; scl_s2_q <= scl_s1_q; scl_prev_q <= scl_s2_q;
      sda_s1_q <= sda_in; sda_s2_q <= sda_s1_q; sda_prev_q <= sda_s2_q;
    end
  end

  // START/STOP need SCL steady high across both samples, so a simultaneous
  // SCL and SDA change is treated as an ordinary data transition.
  assign scl_rise_s = scl_s2_q & ~scl_prev_q;
  assign scl_fall_s = ~scl_s2_q & scl_prev_q;
  assign scl_high_s = scl_s2_q & scl_prev_q;
  assign start_s    = scl_high_s & ~sda_s2_q & sda_prev_q;
  assign stop_s     = scl_high_s & sda_s2_q & ~sda_prev_q;
  assign byte_s     = {sr_q[6:0], sda_s2_q};

  // Protocol state machine: next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    ptr_d      = wr_valid_q ? (ptr_q + PTR_INC) : ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    if (stop_s) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_s) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ADDR: begin
          if (scl_rise_s && (cnt_q < 4'd8)) begin
            sr_d  = byte_s;
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall_s && (cnt_q == 4'd8)) begin
            if (sr_q[7:1] == DEV_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = sr_q[0];
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              sr_d     = rd_data;
              ptr_d    = ptr_q + PTR_INC;
              sda_oe_d = ~rd_data[7];
              state_d  = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_PTR;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_PTR, ST_WDATA: begin
          if (scl_rise_s && (cnt_q < 4'd8)) begin
            sr_d  = byte_s;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q != 4'd7) begin
              wr_valid_d = 1'b0;
            end else if (state_q == ST_PTR) begin
              ptr_d = PTR_W'(byte_s);
            end else begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_s;
            end
          end else if (scl_fall_s && (cnt_q == 4'd8)) begin
            sda_oe_d = 1'b1;
            state_d  = ST_WACK;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_WACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = ST_WDATA;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RDATA: begin
          if (scl_rise_s && (cnt_q < 4'd8)) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall_s) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RDATA_ACK;
            end else begin
              sda_oe_d = ~sr_q[6];
              sr_d     = {sr_q[6:0], 1'b0};
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise_s) begin
            ack_d = ~sda_s2_q;
          end else if (scl_fall_s) begin
            if (ack_q) begin
              sr_d     = rd_data;
              ptr_d    = ptr_q + PTR_INC;
              sda_oe_d = ~rd_data[7];
              cnt_d    = 4'd0;
              state_d  = ST_RDATA;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            ack_d = ack_q;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      sr_q       <= 8'd0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged controller on a wired-AND SDA line, a
// pointer/strobe model of the register port, and a per-cycle strobe monitor.
module tb_i2c_target;
  localparam int QC = 8;

  logic       CLK = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_ptr;
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  logic [15:0] mon_e;
  logic        prev_wv;
  bit          quiet = 1'b0;

  always #5 CLK = ~CLK;

  assign sda_bus = sda_m & ~sda_oe;
  assign rd_data = ~rd_addr;

  i2c_target #(.DEV_ADDR(7'h42), .PTR_W(8)) dut (
    .CLK(CLK), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b;  cyc(QC);
    scl_m = 1'b1; cyc(QC);
    s = sda_bus; cyc(QC);
    scl_m = 1'b0; cyc(QC);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; cyc(QC);
    scl_m = 1'b0; cyc(QC);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; cyc(QC);
    scl_m = 1'b1; cyc(QC);
    sda_m = 1'b0; cyc(QC);
    scl_m = 1'b0; cyc(QC);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; cyc(QC);
    scl_m = 1'b1; cyc(QC);
    sda_m = 1'b1; cyc(QC);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    chk(name, {31'd0, ~s}, {31'd0, exp_ack});
  endtask

  task automatic rd_byte(input logic m_ack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      v[i] = s;
    end
    send_bit(~m_ack, s);
  endtask

  // Model: a data byte written lands at the pointer, then the pointer advances.
  task automatic model_wr(input logic [7:0] b);
    exp_q.push_back({m_ptr, b});
    m_ptr = m_ptr + 8'd1;
  endtask

  // Every wr_valid strobe must match the next model entry and last one cycle.
  always @(negedge CLK) begin
    if (!reset && wr_valid) begin
      wr_log.push_back({wr_addr, wr_data});
      chk("wr_pulse_width", {31'd0, prev_wv}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h, expected no strobe", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_strobe", {16'd0, wr_addr, wr_data}, {16'd0, mon_e});
      end
    end
    if (quiet) chk("no_drive", {31'd0, sda_oe}, 32'd0);
    prev_wv = wr_valid;
  end

  initial begin
    repeat (80000) @(posedge CLK);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] t;
    logic       s;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; prev_wv = 1'b0;
    m_ptr = 8'd0;
    cyc(5);
    reset = 1'b0;
    cyc(2);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Plain write of two bytes starting at 0x10.
    wr_log.delete();
    i2c_start();
    wr_byte(8'h84, 1'b1, "w_addr_ack");
    chk("w_busy", {31'd0, busy}, 32'd1);
    wr_byte(8'h10, 1'b1, "w_ptr_ack");
    m_ptr = 8'h10;
    model_wr(8'hA5); wr_byte(8'hA5, 1'b1, "w_d0_ack");
    model_wr(8'h5A); wr_byte(8'h5A, 1'b1, "w_d1_ack");
    i2c_stop(); cyc(4);
    chk("w_rd_addr", {24'd0, rd_addr}, {24'd0, m_ptr});
    chk("w_rd_addr_lit", {24'd0, rd_addr}, 32'h12);
    chk("w_busy_stop", {31'd0, busy}, 32'd0);
    chk("w_pending", exp_q.size(), 32'd0);
    chk("w_log_n", wr_log.size(), 32'd2);
    if (wr_log.size() == 2) begin
      chk("w_log0", {16'd0, wr_log[0]}, 32'h10A5);
      chk("w_log1", {16'd0, wr_log[1]}, 32'h115A);
    end else begin
      chk("w_log_present", wr_log.size(), 32'd2);
    end

    // Combined read: set pointer 0x20, repeated START, read two bytes.
    wr_log.delete();
    i2c_start();
    wr_byte(8'h84, 1'b1, "r_addrw_ack");
    wr_byte(8'h20, 1'b1, "r_ptr_ack");
    m_ptr = 8'h20;
    i2c_rstart();
    wr_byte(8'h85, 1'b1, "r_addrr_ack");
    rd_byte(1'b1, v);
    chk("r_b0", {24'd0, v}, {24'd0, ~m_ptr});
    chk("r_b0_lit", {24'd0, v}, 32'hDF);
    m_ptr = m_ptr + 8'd1;
    rd_byte(1'b0, v);
    chk("r_b1", {24'd0, v}, {24'd0, ~m_ptr});
    chk("r_b1_lit", {24'd0, v}, 32'hDE);
    m_ptr = m_ptr + 8'd1;
    cyc(4);
    chk("r_busy_nack", {31'd0, busy}, 32'd1);
    chk("r_release_nack", {31'd0, sda_oe}, 32'd0);
    i2c_stop(); cyc(4);
    chk("r_rd_addr", {24'd0, rd_addr}, {24'd0, m_ptr});
    chk("r_rd_addr_lit", {24'd0, rd_addr}, 32'h22);
    chk("r_busy_stop", {31'd0, busy}, 32'd0);
    chk("r_no_strobe", wr_log.size(), 32'd0);

    // Address mismatch: target must stay silent for the whole transaction.
    quiet = 1'b1;
    i2c_start();
    wr_byte(8'h86, 1'b0, "m_addr_nack");
    chk("m_busy", {31'd0, busy}, 32'd0);
    wr_byte(8'h11, 1'b0, "m_d0_nack");
    wr_byte(8'h22, 1'b0, "m_d1_nack");
    i2c_stop(); cyc(4);
    quiet = 1'b0;
    chk("m_busy_end", {31'd0, busy}, 32'd0);
    chk("m_no_strobe", wr_log.size(), 32'd0);

    // Pointer wrap from 0xFF.
    wr_log.delete();
    i2c_start();
    wr_byte(8'h84, 1'b1, "p_addr_ack");
    wr_byte(8'hFF, 1'b1, "p_ptr_ack");
    m_ptr = 8'hFF;
    model_wr(8'h01); wr_byte(8'h01, 1'b1, "p_d0_ack");
    model_wr(8'h02); wr_byte(8'h02, 1'b1, "p_d1_ack");
    i2c_stop(); cyc(4);
    chk("p_log_n", wr_log.size(), 32'd2);
    if (wr_log.size() == 2) begin
      chk("p_log0", {16'd0, wr_log[0]}, 32'hFF01);
      chk("p_log1", {16'd0, wr_log[1]}, 32'h0002);
    end else begin
      chk("p_log_present", wr_log.size(), 32'd2);
    end
    chk("p_rd_addr", {24'd0, rd_addr}, {24'd0, m_ptr});

    // STOP after 4 bits of a data byte discards it.
    wr_log.delete();
    i2c_start();
    wr_byte(8'h84, 1'b1, "s_addr_ack");
    wr_byte(8'h30, 1'b1, "s_ptr_ack");
    m_ptr = 8'h30;
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b1, s);
    i2c_stop(); cyc(4);
    chk("s_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("s_busy", {31'd0, busy}, 32'd0);
    chk("s_rd_addr", {24'd0, rd_addr}, {24'd0, m_ptr});
    chk("s_no_strobe", wr_log.size(), 32'd0);

    // Reset while the target drives a 0 read bit, then a normal write.
    i2c_start();
    wr_byte(8'h84, 1'b1, "x_addrw_ack");
    wr_byte(8'h40, 1'b1, "x_ptr_ack");
    m_ptr = 8'h40;
    i2c_rstart();
    wr_byte(8'h85, 1'b1, "x_addrr_ack");
    t = ~m_ptr;
    send_bit(1'b1, s);
    chk("x_bit7", {31'd0, s}, {31'd0, t[7]});
    sda_m = 1'b1; cyc(QC);
    scl_m = 1'b1; cyc(QC);
    chk("x_drive_bit6", {31'd0, sda_oe}, {31'd0, ~t[6]});
    reset = 1'b1;
    cyc(1);
    chk("x_release", {31'd0, sda_oe}, 32'd0);
    reset = 1'b0;
    m_ptr = 8'd0;
    exp_q.delete();
    wr_log.delete();
    cyc(QC);
    scl_m = 1'b0; cyc(QC);
    i2c_stop(); cyc(4);
    i2c_start();
    wr_byte(8'h84, 1'b1, "x_w_addr_ack");
    wr_byte(8'h50, 1'b1, "x_w_ptr_ack");
    m_ptr = 8'h50;
    model_wr(8'h77); wr_byte(8'h77, 1'b1, "x_w_d0_ack");
    i2c_stop(); cyc(4);
    chk("x_rd_addr", {24'd0, rd_addr}, 32'h51);
    chk("x_log_n", wr_log.size(), 32'd1);
    if (wr_log.size() == 1) begin
      chk("x_log0", {16'd0, wr_log[0]}, 32'h5077);
    end else begin
      chk("x_log_present", wr_log.size(), 32'd1);
    end
    chk("x_pending", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
